// File: rtl/mau_stream_pkg.sv
// Shared types, instruction field positions and sizing helper for the
// streaming matrix engine.
package mau_stream_pkg;

   typedef enum logic [3:0] {
      OP_NOP   = 4'd0,
      OP_LOAD  = 4'd1,
      OP_STORE = 4'd2,
      OP_ADD   = 4'd3,
      OP_SUB   = 4'd4,
      OP_SHL   = 4'd5,
      OP_MUL   = 4'd6,
      OP_COPY  = 4'd7,
      OP_CLEAR = 4'd8
   } opcode_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_STORE = 2'd2,
      ST_EXEC  = 2'd3
   } state_e;

   localparam int unsigned FIELD_W  = 4;
   localparam int unsigned OPC_LSB  = 12;
   localparam int unsigned DST_LSB  = 8;
   localparam int unsigned SRCA_LSB = 4;
   localparam int unsigned SRCB_LSB = 0;

   // Index/address width, never narrower than one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mau_elem_alu.sv
// Combinational per-element ALU. Define MAU_SATURATE_EN to clamp ADD/SUB/
// SHL/MUL results instead of wrapping.
module mau_elem_alu
   import mau_stream_pkg::*;
#(
   parameter int unsigned ELEM_W = 8
) (
   input  logic [3:0]        op,
   input  logic [ELEM_W-1:0] a,
   input  logic [ELEM_W-1:0] b,
   output logic [ELEM_W-1:0] result
);

`ifdef MAU_SATURATE_EN
   logic [ELEM_W:0]     sum;
   logic [2*ELEM_W-1:0] prod;
   logic [ELEM_W+7:0]   shifted;

   always_comb begin
      sum     = {1'b0, a} + {1'b0, b};
      prod    = {{ELEM_W{1'b0}}, a} * {{ELEM_W{1'b0}}, b};
      shifted = {8'd0, a} << b[2:0];
   end
`endif

   always_comb begin
      result = '0;
      case (op)
`ifdef MAU_SATURATE_EN
         OP_ADD:  result = sum[ELEM_W] ? '1 : sum[ELEM_W-1:0];
         OP_SUB:  result = (a < b) ? '0 : a - b;
         OP_SHL:  result = (|shifted[ELEM_W+7:ELEM_W]) ? '1 : shifted[ELEM_W-1:0];
         OP_MUL:  result = (|prod[2*ELEM_W-1:ELEM_W]) ? '1 : prod[ELEM_W-1:0];
`else
         OP_ADD:  result = a + b;
         OP_SUB:  result = a - b;
         OP_SHL:  result = a << b[2:0];
         OP_MUL:  result = a * b;
`endif
         OP_COPY:  result = a;
         OP_CLEAR: result = '0;
         default:  result = '0;
      endcase
   end

endmodule

// File: rtl/mau_stream_engine.sv
// Banked matrix engine with valid/ready host streams and a serial element
// ALU. Optional saturation lives in mau_elem_alu (macro MAU_SATURATE_EN).
module mau_stream_engine
   import mau_stream_pkg::*;
#(
   parameter int unsigned DIM       = 8,
   parameter int unsigned ELEM_W    = 8,
   parameter int unsigned NUM_BANKS = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [15:0]       instr,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [ELEM_W-1:0] data_in,
   input  logic              data_in_valid,
   output logic              data_in_ready,
   output logic [ELEM_W-1:0] data_out,
   output logic              data_out_valid,
   input  logic              data_out_ready,
   output logic              busy,
   output logic              error
);

   localparam int unsigned N  = DIM * DIM;
   localparam int unsigned IW = idx_width(N);
   localparam int unsigned AW = idx_width(NUM_BANKS * N);

   localparam logic [1:0] IDLE  = 2'(ST_IDLE);
   localparam logic [1:0] LOAD  = 2'(ST_LOAD);
   localparam logic [1:0] STORE = 2'(ST_STORE);
   localparam logic [1:0] EXEC  = 2'(ST_EXEC);

   logic [ELEM_W-1:0] mem [NUM_BANKS*N];

   logic [1:0]        state;
   logic [IW-1:0]     idx;
   logic [IW-1:0]     idx_next;
   logic              idx_last;
   logic [3:0]        op_q, dst_q, a_q, b_q;

   logic [3:0]        opc, dst_f, a_f, b_f;
   logic              legal, use_a, use_b;
   logic [ELEM_W-1:0] alu_a, alu_b, alu_res;
   logic              we;
   logic [ELEM_W-1:0] wdata;

   function automatic logic bank_ok(input logic [3:0] f);
      return {1'b0, f} < 5'(NUM_BANKS);
   endfunction

   function automatic logic [AW-1:0] addr(input logic [3:0] bank, input logic [IW-1:0] i);
      return AW'(bank) * AW'(N) + AW'(i);
   endfunction

   always_comb begin
      opc   = instr[OPC_LSB  +: FIELD_W];
      dst_f = instr[DST_LSB  +: FIELD_W];
      a_f   = instr[SRCA_LSB +: FIELD_W];
      b_f   = instr[SRCB_LSB +: FIELD_W];
      legal = 1'b0;
      use_a = 1'b0;
      use_b = 1'b0;
      case (opc)
         OP_NOP:   legal = 1'b1;
         OP_LOAD,
         OP_CLEAR: legal = bank_ok(dst_f);
         OP_STORE: begin
            legal = bank_ok(a_f);
            use_a = 1'b1;
         end
         OP_COPY: begin
            legal = bank_ok(dst_f) && bank_ok(a_f);
            use_a = 1'b1;
         end
         OP_ADD, OP_SUB, OP_SHL, OP_MUL: begin
            legal = bank_ok(dst_f) && bank_ok(a_f) && bank_ok(b_f);
            use_a = 1'b1;
            use_b = 1'b1;
         end
         default: legal = 1'b0;
      endcase
   end

   always_comb begin
      idx_next = idx + 1'b1;
      idx_last = (idx == IW'(N - 1));
   end

   // Unused source fields are latched as bank 0 so reads never leave the array.
   always_comb begin
      alu_a = mem[addr(a_q, idx)];
      alu_b = mem[addr(b_q, idx)];
   end

   mau_elem_alu #(.ELEM_W(ELEM_W)) u_alu (
      .op     (op_q),
      .a      (alu_a),
      .b      (alu_b),
      .result (alu_res)
   );

   always_comb begin
      we    = 1'b0;
      wdata = alu_res;
      if (state == LOAD && data_in_valid) begin
         we    = 1'b1;
         wdata = data_in;
      end else if (state == EXEC) begin
         we = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (we) mem[addr(dst_q, idx)] <= wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         idx            <= '0;
         data_out       <= '0;
         data_out_valid <= 1'b0;
         error          <= 1'b0;
         op_q           <= '0;
         dst_q          <= '0;
         a_q            <= '0;
         b_q            <= '0;
      end else begin
         error <= 1'b0;
         case (state)
            IDLE: begin
               idx <= '0;
               if (instr_valid) begin
                  if (!legal) begin
                     error <= 1'b1;
                  end else if (opc != OP_NOP) begin
                     op_q  <= opc;
                     dst_q <= dst_f;
                     a_q   <= use_a ? a_f : '0;
                     b_q   <= use_b ? b_f : '0;
                     if (opc == OP_LOAD) begin
                        state <= LOAD;
                     end else if (opc == OP_STORE) begin
                        data_out       <= mem[addr(a_f, '0)];
                        data_out_valid <= 1'b1;
                        state          <= STORE;
                     end else begin
                        state <= EXEC;
                     end
                  end
               end
            end
            LOAD: begin
               if (data_in_valid) begin
                  idx <= idx_last ? '0 : idx_next;
                  if (idx_last) state <= IDLE;
               end
            end
            STORE: begin
               if (data_out_ready) begin
                  if (idx_last) begin
                     idx            <= '0;
                     data_out_valid <= 1'b0;
                     state          <= IDLE;
                  end else begin
                     idx      <= idx_next;
                     data_out <= mem[addr(a_q, idx_next)];
                  end
               end
            end
            default: begin
               idx <= idx_last ? '0 : idx_next;
               if (idx_last) state <= IDLE;
            end
         endcase
      end
   end

   always_comb begin
      instr_ready   = (state == IDLE);
      data_in_ready = (state == LOAD);
      busy          = (state != IDLE);
   end

endmodule

// File: tb/tb_mau_stream_engine.sv
// Directed bench for mau_stream_engine at DIM=2, ELEM_W=8, NUM_BANKS=4;
// expected values follow MAU_SATURATE_EN when it is defined.
module tb_mau_stream_engine;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic [7:0]  data_in;
   logic        data_in_valid;
   logic        data_in_ready;
   logic [7:0]  data_out;
   logic        data_out_valid;
   logic        data_out_ready;
   logic        busy;
   logic        error;

   int unsigned checks = 0;
   int unsigned errors = 0;

   always #5 clk = ~clk;

   mau_stream_engine #(.DIM(2), .ELEM_W(8), .NUM_BANKS(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .instr          (instr),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .data_in        (data_in),
      .data_in_valid  (data_in_valid),
      .data_in_ready  (data_in_ready),
      .data_out       (data_out),
      .data_out_valid (data_out_valid),
      .data_out_ready (data_out_ready),
      .busy           (busy),
      .error          (error)
   );

   typedef struct {
      logic [15:0] word;
      logic [31:0] expect_elems;
      string       name;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out waiting for the engine", name);
   endtask

   function automatic logic [15:0] mk(input int op, input int d, input int a, input int b);
      return {4'(op), 4'(d), 4'(a), 4'(b)};
   endfunction

   task automatic send(input logic [15:0] w);
      int unsigned n = 0;
      while (!instr_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!instr_ready) timeout("instr_ready");
      instr       = w;
      instr_valid = 1'b1;
      @(negedge clk);
      instr_valid = 1'b0;
   endtask

   task automatic load_elems(input logic [31:0] vals, input int count);
      for (int i = 0; i < count; i++) begin
         int unsigned n = 0;
         while (!data_in_ready && n < 100) begin
            @(negedge clk);
            n++;
         end
         if (!data_in_ready) timeout("data_in_ready");
         data_in       = vals[31-8*i -: 8];
         data_in_valid = 1'b1;
         @(negedge clk);
      end
      data_in_valid = 1'b0;
   endtask

   task automatic stream_check(input string name, input logic [31:0] exp);
      for (int i = 0; i < 4; i++) begin
         int unsigned n = 0;
         while (!data_out_valid && n < 100) begin
            @(negedge clk);
            n++;
         end
         if (!data_out_valid) timeout(name);
         check($sformatf("%s[%0d]", name, i), 32'(data_out), 32'(exp[31-8*i -: 8]));
         data_out_ready = 1'b1;
         @(negedge clk);
         data_out_ready = 1'b0;
      end
      check({name, " valid_low"}, 32'(data_out_valid), 32'd0);
      check({name, " busy_low"}, 32'(busy), 32'd0);
   endtask

   task automatic store_check(input int bank, input string name, input logic [31:0] exp);
      send(mk(2, 0, bank, 0));
      stream_check(name, exp);
   endtask

   vec_t vecs [6];
   int unsigned busy_cycles;

   initial begin
`ifdef MAU_SATURATE_EN
      vecs[0] = '{mk(3, 2, 0, 1), 32'hFF_FF_0D_04, "add"};
      vecs[1] = '{mk(4, 3, 0, 1), 32'h00_00_00_04, "sub"};
      vecs[2] = '{mk(5, 2, 1, 0), 32'hFF_FF_50_00, "shl"};
      vecs[3] = '{mk(6, 2, 1, 0), 32'hFF_FF_1E_00, "mul"};
`else
      vecs[0] = '{mk(3, 2, 0, 1), 32'h00_00_0D_04, "add"};
      vecs[1] = '{mk(4, 3, 0, 1), 32'h02_04_F9_04, "sub"};
      vecs[2] = '{mk(5, 2, 1, 0), 32'hFE_F8_50_00, "shl"};
      vecs[3] = '{mk(6, 2, 1, 0), 32'hFF_FC_1E_00, "mul"};
`endif
      vecs[4] = '{mk(7, 3, 1, 0), 32'hFF_FE_0A_00, "copy"};
      vecs[5] = '{mk(8, 3, 0, 0), 32'h00_00_00_00, "clear"};

      rst            = 1'b1;
      instr          = '0;
      instr_valid    = 1'b0;
      data_in        = '0;
      data_in_valid  = 1'b0;
      data_out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst instr_ready", 32'(instr_ready), 32'd1);
      check("rst data_in_ready", 32'(data_in_ready), 32'd0);
      check("rst data_out_valid", 32'(data_out_valid), 32'd0);
      check("rst data_out", 32'(data_out), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst error", 32'(error), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      send(mk(1, 0, 0, 0));
      check("load busy", 32'(busy), 32'd1);
      load_elems(32'h01_02_03_04, 4);
      check("load done busy", 32'(busy), 32'd0);
      send(mk(1, 1, 0, 0));
      load_elems(32'hFF_FE_0A_00, 4);

      // Stalled store: element 0 must hold while ready is low.
      send(mk(2, 0, 0, 0));
      for (int k = 0; k < 3; k++) begin
         check($sformatf("stall valid %0d", k), 32'(data_out_valid), 32'd1);
         check($sformatf("stall hold %0d", k), 32'(data_out), 32'd1);
         @(negedge clk);
      end
      stream_check("store b0", 32'h01_02_03_04);

      for (int v = 0; v < 6; v++) begin
         send(vecs[v].word);
         store_check(int'(vecs[v].word[11:8]), vecs[v].name, vecs[v].expect_elems);
      end

      send(mk(6, 0, 0, 0));
      busy_cycles = 0;
      while (busy && busy_cycles < 20) begin
         busy_cycles++;
         @(negedge clk);
      end
      check("mul inplace busy cycles", busy_cycles, 32'd4);
      store_check(0, "mul inplace", 32'h01_04_09_10);

      send(mk(3, 5, 0, 1));
      check("bad dst error", 32'(error), 32'd1);
      check("bad dst instr_ready", 32'(instr_ready), 32'd1);
      check("bad dst busy", 32'(busy), 32'd0);
      @(negedge clk);
      check("bad dst error pulse", 32'(error), 32'd0);
      send(16'hC000);
      check("bad opc error", 32'(error), 32'd1);
      check("bad opc instr_ready", 32'(instr_ready), 32'd1);
      @(negedge clk);
      check("bad opc error pulse", 32'(error), 32'd0);
      send(16'h0000);
      check("nop error", 32'(error), 32'd0);
      check("nop busy", 32'(busy), 32'd0);
      store_check(0, "after reject b0", 32'h01_04_09_10);
      store_check(1, "after reject b1", 32'hFF_FE_0A_00);

      send(mk(1, 1, 0, 0));
      load_elems(32'h07_08_00_00, 2);
      rst = 1'b1;
      #1;
      check("midrst busy", 32'(busy), 32'd0);
      check("midrst data_in_ready", 32'(data_in_ready), 32'd0);
      check("midrst instr_ready", 32'(instr_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      store_check(1, "after rst b1", 32'h07_08_0A_00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
